// File: rtl/imem_fetch_port.sv
// imem_fetch_port: synchronous instruction memory between fetch and decode.
// Fetch side uses a valid/ready handshake with a one-entry registered
// response that holds while decode stalls. A LOAD mode lets a loader
// write the program at run time. A branch flush discards the in-flight response.
// Optional feature macro: IMEM_BOUNDS_CHECK_EN. When it is defined,
// misaligned or out-of-range fetches return NOP_WORD with resp_fault set,
// and such loads are dropped. When it is not defined, addresses wrap
// modulo DEPTH and the low two address bits are ignored.
module imem_fetch_port #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 1024,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_fault,
  input  logic              flush,
  input  logic              load_start,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              loading
);

  localparam int IDX_W = $clog2(DEPTH);

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_CHECK = 1'b1;
`else
  localparam bit BOUNDS_CHECK = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_fault_q, resp_fault_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  req_idx_s;
  logic [IDX_W-1:0]  load_idx_s;
  logic              req_bad_s;
  logic              load_bad_s;
  logic              req_ready_s;
  logic              accept_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] rd_word_s;

  // Decode word indices. Flag misaligned or out-of-range addresses; the flag is used only when bounds checking is built in.
  always_comb begin
    req_idx_s  = req_addr[IDX_W+1:2];
    load_idx_s = load_addr[IDX_W+1:2];
    req_bad_s  = BOUNDS_CHECK &&
                 ((|req_addr[ADDR_W-1:IDX_W+2]) || (|req_addr[1:0]));
    load_bad_s = BOUNDS_CHECK &&
                 ((|load_addr[ADDR_W-1:IDX_W+2]) || (|load_addr[1:0]));
  end

  // Handshake: fetch accepted only in RUN, never during flush, and only when the output slot frees up.
  always_comb begin
    req_ready_s = (state_q == ST_RUN) && !flush && (!resp_valid_q || resp_ready);
    accept_s    = req_valid && req_ready_s;
    mem_we_s    = (state_q == ST_LOAD) && load_we && !load_bad_s;
    rd_word_s   = mem_q[req_idx_s];
  end

  // Mode next-state: load_start enters LOAD and load_done returns to RUN; each is ignored in the other mode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (load_done) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Response slot next-state: flush beats accept, accept beats consume; data only changes on accept.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    if (flush) begin
      resp_valid_d = 1'b0;
    end else if (accept_s) begin
      resp_valid_d = 1'b1;
      resp_data_d  = req_bad_s ? NOP_WORD : rd_word_s;
      resp_fault_d = req_bad_s;
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end else begin
      resp_valid_d = resp_valid_q;
    end
  end

  // Mode and response registers; reset empties the slot and returns to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      resp_valid_q <= 1'b0;
      resp_data_q  <= NOP_WORD;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Program storage; deliberately not reset so a loaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[load_idx_s] <= load_data;
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_fault = resp_fault_q;
  assign loading    = (state_q == ST_LOAD);

endmodule

// File: tb/tb_imem_fetch_port.sv
// Self-checking bench for imem_fetch_port: table-driven fetch vectors,
// hand-written corner sequences and a randomized phase checked against
// a transaction-level reference model (word array + response queue).
module tb_imem_fetch_port;

  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 1024;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_fault;
  logic              flush;
  logic              load_start;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              loading;

  imem_fetch_port #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_fault(resp_fault), .flush(flush),
    .load_start(load_start), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done), .loading(loading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    bit          fault;
  } resp_t;

  logic [31:0] m_mem [DEPTH];
  bit          m_loading;
  resp_t       m_q [$];   // holds the response currently offered to decode

  function automatic bit m_bad(input logic [31:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
    return ((a >> 2) >= DEPTH) || (a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !m_loading && !flush && (m_q.size() == 0 || resp_ready);
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic tick();
    bit rr;
    bit acc;
    resp_t r;
    @(negedge clk);
    rr = m_ready();
    cmp("req_ready", req_ready, rr);
    cmp("loading", loading, m_loading);
    cmp("resp_valid", resp_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      cmp("resp_data", resp_data, m_q[0].data);
      cmp("resp_fault", resp_fault, m_q[0].fault);
    end
    @(posedge clk);
    #1;
    acc = req_valid && rr;
    if (m_loading && load_we && !m_bad(load_addr)) m_mem[m_idx(load_addr)] = load_data;
    if (!m_loading && load_start) m_loading = 1'b1;
    else if (m_loading && load_done) m_loading = 1'b0;
    if (flush) begin
      m_q.delete();
    end else begin
      if (m_q.size() != 0 && resp_ready) m_q.delete();
      if (acc) begin
        r.fault = m_bad(req_addr);
        r.data  = r.fault ? NOP : m_mem[m_idx(req_addr)];
        m_q.push_back(r);
      end
    end
  endtask

  task automatic clear_inputs();
    req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0; flush = 1'b0;
    load_start = 1'b0; load_we = 1'b0; load_addr = 32'h0; load_data = 32'h0;
    load_done = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    bit          exp_fault;
  } vec_t;

  logic [31:0] prog [7];
  vec_t        vecs [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prog = '{32'h0000_0000, 32'h8001_0829, 32'h8002_0109, 32'h0000_0000,
             32'h0000_0000, 32'hFC22_0000, 32'h0421_1800};
    for (int i = 0; i < 7; i++) vecs[i] = '{32'(4 * i), prog[i], 1'b0};
`ifdef IMEM_BOUNDS_CHECK_EN
    vecs[7] = '{32'd4096, NOP, 1'b1};
    vecs[8] = '{32'd6, NOP, 1'b1};
`else
    vecs[7] = '{32'd4096, prog[0], 1'b0};
    vecs[8] = '{32'd6, prog[1], 1'b0};
`endif

    // ---- reset values ----
    clear_inputs();
    rst_n = 1'b0;
    m_loading = 1'b0;
    m_q.delete();
    #12;
    cmp("rst_resp_valid", resp_valid, 1'b0);
    cmp("rst_resp_data", resp_data, NOP);
    cmp("rst_resp_fault", resp_fault, 1'b0);
    cmp("rst_loading", loading, 1'b0);
    cmp("rst_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- program load ----
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    cmp("load_entered", loading, 1'b1);
    for (int i = 0; i < 7; i++) load_word(32'(4 * i), prog[i]);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    cmp("load_left", loading, 1'b0);

    // ---- table-driven streaming fetch ----
    resp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1;
      req_addr  = vecs[i].addr;
      tick();
      cmp($sformatf("vec%0d_valid", i), resp_valid, 1'b1);
      cmp($sformatf("vec%0d_data", i), resp_data, vecs[i].exp_data);
      cmp($sformatf("vec%0d_fault", i), resp_fault, vecs[i].exp_fault);
    end
    req_valid = 1'b0;
    tick();

    // ---- stall hold ----
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'd4;
    tick();
    req_addr = 32'd8;
    for (int i = 0; i < 3; i++) begin
      #1 cmp("hold_req_ready", req_ready, 1'b0);
      tick();
      cmp("hold_data", resp_data, 32'h8001_0829);
      cmp("hold_valid", resp_valid, 1'b1);
    end
    resp_ready = 1'b1;
    #1 cmp("release_req_ready", req_ready, 1'b1);
    tick();
    cmp("release_next_data", resp_data, 32'h8002_0109);
    req_valid = 1'b0;
    tick();

    // ---- flush ----
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'd8;
    tick();
    flush = 1'b1; req_addr = 32'd12;
    #1 cmp("flush_req_ready", req_ready, 1'b0);
    tick();
    flush = 1'b0;
    cmp("flush_valid", resp_valid, 1'b0);
    resp_ready = 1'b1;
    tick();
    cmp("after_flush_valid", resp_valid, 1'b1);
    cmp("after_flush_data", resp_data, 32'h0000_0000);
    req_valid = 1'b0;
    tick();

    // ---- fetch blocked in LOAD, write on load_done edge ----
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'd20;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 cmp("load_req_ready", req_ready, 1'b0);
      tick();
      cmp("load_held_valid", resp_valid, 1'b1);
    end
    load_we = 1'b1; load_addr = 32'd8; load_data = 32'hDEAD_BEEF; load_done = 1'b1;
    tick();
    load_we = 1'b0; load_done = 1'b0;
    resp_ready = 1'b1; req_addr = 32'd8;
    tick();
    cmp("wr_at_done_data", resp_data, 32'hDEAD_BEEF);
    req_valid = 1'b0;
    tick();

    // ---- reset mid-operation ----
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'd0; load_start = 1'b1;
    tick();
    clear_inputs();
    cmp("pre_rst_valid", resp_valid, 1'b1);
    cmp("pre_rst_loading", loading, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    cmp("mid_rst_valid", resp_valid, 1'b0);
    cmp("mid_rst_loading", loading, 1'b0);
    cmp("mid_rst_req_ready", req_ready, 1'b1);
    m_q.delete();
    m_loading = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'd20;
    tick();
    cmp("post_rst_w5", resp_data, 32'hFC22_0000);
    req_addr = 32'd8;
    tick();
    cmp("post_rst_w2", resp_data, 32'hDEAD_BEEF);
    req_valid = 1'b0;
    tick();

    // ---- randomized traffic against the model ----
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 64; i++) load_word(32'(4 * i), $urandom);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] fa;
      logic [31:0] la;
      fa = 32'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 7) == 0) fa = fa + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) fa = fa + 32'd4096 * 32'($urandom_range(1, 5));
      la = 32'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 7) == 0) la = la + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) la = la + 32'd4096;
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = fa;
      resp_ready = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 9) == 0);
      load_start = ($urandom_range(0, 39) == 0);
      load_done  = ($urandom_range(0, 5) == 0);
      load_we    = ($urandom_range(0, 1) == 0);
      load_addr  = la;
      load_data  = $urandom;
      tick();
    end
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
